// File: rtl/cache_axi_rd_resp_pkg.sv
// rtl/cache_axi_rd_resp_pkg.sv - shared FSM encodings and AXI4 constants for the cache read path
// Purpose: state encodings and AXI4 AR/R field constants used by cache_axi_rd_resp.
// Ports: none (package).
package cache_axi_rd_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/cache_axi_rd_resp_rd_beat_counter.sv
// rtl/cache_axi_rd_resp_rd_beat_counter.sv - R-channel beat counter with burst length guard
// Purpose: counts accepted beats of the current burst and flags the burst end, either by
//          rlast or by reaching the latched length when the slave never asserts rlast.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset
//   clear      - restart the count (request accepted, entering AR)
//   beat       - an R beat is accepted this cycle
//   len        - latched burst length (beats minus one)
//   rlast      - slave's last-beat marker
//   at_len     - current beat index equals the latched length
//   done       - accepted beat ends the burst
//   guard      - burst ends on length while rlast is still low
module rd_beat_counter
  import cache_axi_rd_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       beat,
  input  logic [7:0] len,
  input  logic       rlast,
  output logic       at_len,
  output logic       done,
  output logic       guard
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (beat) begin
      count_q <= count_q + 8'd1;
    end
  end

  // count_q holds the index of the beat currently presented on R.
  assign at_len = (count_q == len);
  assign done   = beat && (rlast || at_len);
  assign guard  = beat && !rlast && at_len;

endmodule

// File: rtl/cache_axi_rd_resp.sv
// rtl/cache_axi_rd_resp.sv - cache read request to AXI4 AR/R burst bridge
// Purpose: accepts one cache read burst at a time, issues it on AR, and forwards R beats
//          combinationally to the cache. Optional macro AXI_RRESP_CHECK_EN enables ret_err.
// Ports:
//   clk, rstn                               - clock, synchronous active-low reset
//   r_req, r_addr, r_length, r_rdy          - cache request (r_rdy pulses on acceptance)
//   ret_valid, ret_last, ret_data, ret_err  - return beats to the cache
//   r_data_ready                            - cache can take a beat
//   arid..arready                           - AXI4 read address channel
//   rid..rready                             - AXI4 read data channel
module cache_axi_rd_resp
  import cache_axi_rd_resp_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        r_req,
  input  logic [31:0] r_addr,
  input  logic [7:0]  r_length,
  output logic        r_rdy,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] ret_data,
  output logic        ret_err,
  input  logic        r_data_ready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  rd_state_e   state_q, state_d;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic        accept;
  logic        beat;
  logic        at_len;
  logic        done;
  logic        guard;

  // Single-ID system: rid is not checked, beats are forwarded regardless.
  logic unused_rid;
  assign unused_rid = ^rid;

  assign accept = (state_q == ST_IDLE) && r_req;
  assign beat   = (state_q == ST_R) && rvalid && r_data_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'd0;
      len_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= r_addr;
        len_q  <= r_length;
      end
    end
  end

  rd_beat_counter u_beat_counter (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (accept),
    .beat   (beat),
    .len    (len_q),
    .rlast  (rlast),
    .at_len (at_len),
    .done   (done),
    .guard  (guard)
  );

  always_comb begin
    state_d   = state_q;
    r_rdy     = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = 32'd0;
    case (state_q)
      ST_IDLE: begin
        r_rdy = r_req;
        if (r_req) state_d = ST_AR;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        rready    = r_data_ready;
        ret_valid = rvalid;
        ret_data  = rdata;
        // Length guard marks the final beat even if the slave never raises rlast.
        ret_last  = rlast || (rvalid && at_len) || guard;
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

`ifdef AXI_RRESP_CHECK_EN
  logic err_q;
  logic beat_err;

  assign beat_err = beat && (rresp != AXI_RESP_OKAY);

  // Sticky until the next accepted request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (r_rdy) begin
      err_q <= 1'b0;
    end else if (beat_err) begin
      err_q <= 1'b1;
    end
  end

  assign ret_err = err_q || beat_err;
`else
  logic unused_rresp;
  assign unused_rresp = ^rresp;
  assign ret_err = 1'b0;
`endif

endmodule
